// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - active-low 7-segment pattern decoder with stability filter and change counter
module seg7_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [6:0]       seg7_in,
    output logic [3:0]       digit,
    output logic             valid,
    output logic             blank,
    output logic             err,
    output logic             update,
    output logic [CNT_W-1:0] change_count
);

    localparam logic [7:0]       S_L     = 8'(STABLE_CYCLES);
    localparam logic [6:0]       ALL_OFF = 7'b1111111;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [6:0] sample_q;
    logic [7:0] run_q;
    logic       pending_q;

    logic       match;
    logic [7:0] run_next;
    logic       pending_next;
    logic       dec_hit;
    logic [3:0] dec_val;
    logic       new_valid;
    logic       new_blank;
    logic       new_err;
    logic [3:0] new_digit;
    logic       changed;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0011000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    always_comb begin
        match    = (seg7_in == sample_q);
        run_next = 8'd1;
        if (match) begin
            run_next = (run_q < S_L) ? run_q + 8'd1 : run_q;
        end
        // A fresh load counts as a transition too, which matters when the threshold is 1.
        pending_next = (run_next == S_L) && (!match || (run_q != S_L));
    end

    always_comb begin
        {dec_hit, dec_val} = decode(sample_q);
        new_valid = dec_hit;
        new_blank = (sample_q == ALL_OFF);
        new_err   = !dec_hit && !new_blank;
        new_digit = dec_hit ? dec_val : digit;
        changed   = {new_valid, new_blank, new_err, new_digit} != {valid, blank, err, digit};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q     <= ALL_OFF;
            run_q        <= 8'd0;
            pending_q    <= 1'b0;
            digit        <= 4'h0;
            valid        <= 1'b0;
            blank        <= 1'b0;
            err          <= 1'b0;
            update       <= 1'b0;
            change_count <= '0;
        end else begin
            update <= 1'b0;
            if (en) begin
                sample_q  <= seg7_in;
                run_q     <= run_next;
                pending_q <= pending_next;
                // Commit uses the stored sample, not the pattern arriving on this edge.
                if (pending_q) begin
                    digit <= new_digit;
                    valid <= new_valid;
                    blank <= new_blank;
                    err   <= new_err;
                    if (changed) begin
                        update <= 1'b1;
                        if (change_count != CNT_MAX) begin
                            change_count <= change_count + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
